// File: rtl/led_pwm_sequencer_pkg.sv
// Shared constants, channel control bundle and helpers
// for the LED PWM colour sequencer.
package axc3000_led_pkg;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_FADE = 1'b1;

  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 8;
  localparam int PWM_BITS_MIN = 4;
  localparam int PWM_BITS_MAX = 16;

  localparam int DUTY_W = PWM_BITS_MAX;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef struct packed {
    logic period_end;
    logic run;
    logic mode;
  } ch_ctl_t;

  function automatic bit params_legal(
    input int num_ch,
    input int pwm_bits,
    input int step_periods
  );
    return (num_ch >= NUM_CH_MIN) &&
           (num_ch <= NUM_CH_MAX) &&
           (pwm_bits >= PWM_BITS_MIN) &&
           (pwm_bits <= PWM_BITS_MAX) &&
           (step_periods >= 1);
  endfunction

  function automatic duty_t step_toward(
    input duty_t cur,
    input duty_t tgt
  );
    duty_t nxt;
    unique case (1'b1)
      (cur < tgt): nxt = cur + duty_t'(1);
      (cur > tgt): nxt = cur - duty_t'(1);
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_pwm_sequencer_if.sv
// Control and status bundle between the board top
// and the LED PWM sequencer.
interface led_pwm_sequencer_if #(
  parameter int NUM_CH   = 3,
  parameter int PWM_BITS = 8
);

  logic                enable;
  logic                up_down;
  logic                mode;
  logic [PWM_BITS-1:0] brightness;
  logic [NUM_CH-1:0]   led;
  logic [NUM_CH-1:0]   index;
  logic                step_pulse;

  modport master (
    output enable,
    output up_down,
    output mode,
    output brightness,
    input  led,
    input  index,
    input  step_pulse
  );

  modport slave (
    input  enable,
    input  up_down,
    input  mode,
    input  brightness,
    output led,
    output index,
    output step_pulse
  );

endinterface

// File: rtl/led_pwm_sequencer_channel.sv
// One LED channel: duty tracking/ramping, period-aligned
// duty reload and the registered PWM comparator.
module led_pwm_channel
  import axc3000_led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk_2m,
  input  logic                combo_reset,
  input  ch_ctl_t             ctl,
  input  logic                lit,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led,
  output logic                settled
);

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_cur;
  logic [PWM_BITS-1:0] duty_active;
  logic [PWM_BITS-1:0] duty_ramp;

  assign target = lit ? brightness : '0;

  assign duty_ramp = PWM_BITS'(step_toward(
    duty_t'(duty_cur),
    duty_t'(target)
  ));

  assign settled = (duty_cur == target);

  // duty_active only moves on a period boundary so a
  // PWM period never mixes two duty values
  always_ff @(posedge clk_2m) begin
    if (combo_reset) begin
      duty_cur    <= '0;
      duty_active <= '0;
      led         <= ACTIVE_LOW;
    end else begin
      if (ctl.period_end) begin
        duty_active <= duty_cur;
      end
      if (ctl.run) begin
        if (ctl.mode == MODE_STEP) begin
          duty_cur <= target;
        end else if (ctl.period_end) begin
          duty_cur <= duty_ramp;
        end
      end
      led <= (pwm_cnt < duty_active) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/led_pwm_sequencer.sv
// Colour-index sequencer driving NUM_CH PWM LED channels
// with hard-step or linear-fade transitions.
module led_pwm_sequencer
  import axc3000_led_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 1000,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input logic               clk_2m,
  input logic               combo_reset,
  led_pwm_sequencer_if.slave bus
);

  localparam int PW =
    (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PW-1:0] PRESC_LAST =
    PW'(STEP_PERIODS - 1);

  if (!params_legal(NUM_CH, PWM_BITS, STEP_PERIODS))
  begin : g_bad_params
    $error("led_pwm_sequencer: illegal parameters");
  end

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PW-1:0]       presc;
  logic [NUM_CH-1:0]   index_q;
  logic [NUM_CH-1:0]   led_w;
  logic [NUM_CH-1:0]   settled;
  logic                pulse_q;
  logic                period_end;
  logic                tick;
  logic                all_settled;
  logic                advance;
  ch_ctl_t             ctl;

  assign period_end = &pwm_cnt;

  assign tick = period_end &&
                bus.enable &&
                (presc == PRESC_LAST);

  assign all_settled = &settled;

  // in fade mode a tick is dropped until every
  // channel has reached its target
  assign advance = tick &&
                   ((bus.mode == MODE_STEP) ||
                    all_settled);

  assign ctl.period_end = period_end;
  assign ctl.run        = bus.enable;
  assign ctl.mode       = bus.mode;

  always_ff @(posedge clk_2m) begin
    if (combo_reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk_2m) begin
    if (combo_reset) begin
      presc <= '0;
    end else if (period_end && bus.enable) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_2m) begin
    if (combo_reset) begin
      index_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= advance;
      if (advance) begin
        if (bus.up_down) begin
          index_q <= index_q + NUM_CH'(1);
        end else begin
          index_q <= index_q - NUM_CH'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk_2m      (clk_2m),
      .combo_reset (combo_reset),
      .ctl         (ctl),
      .lit         (index_q[c]),
      .pwm_cnt     (pwm_cnt),
      .brightness  (bus.brightness),
      .led         (led_w[c]),
      .settled     (settled[c])
    );
  end

  assign bus.led        = led_w;
  assign bus.index      = index_q;
  assign bus.step_pulse = pulse_q;

endmodule

// File: doc/led_pwm_sequencer.md
Name: led_pwm_sequencer

Overview:
- Parametrised successor to the board's free-running RGB colour counter.
- Drives NUM_CH LED channels with per-channel PWM brightness instead of raw counter MSBs.
- Steps a colour index up or down through all 2^NUM_CH on/off combinations, in either hard-step or linear-fade mode.
- Sits between the PLL-derived clock domain and the LED pins in the top level.

Parameters:
NUM_CH, 3, number of LED channels / index width (legal 1..8)
PWM_BITS, 8, PWM counter and duty width (legal 4..16)
STEP_PERIODS, 1000, PWM periods per sequencer tick (>=1)
ACTIVE_LOW, 0, 1 inverts every led output

Ports:
clk_2m  in  1  single clock, all state on rising edge
combo_reset  in  1  synchronous, active-high reset
enable  in  1  1 = sequencer and fade run; 0 = freeze index/prescaler/duty_cur (PWM keeps running)
up_down  in  1  1 = index increments, 0 = decrements; sampled at tick
mode  in  1  0 = STEP, 1 = FADE
brightness  in  PWM_BITS  on-level duty for lit channels, sampled live
led  out  NUM_CH  registered PWM outputs
index  out  NUM_CH  current colour index
step_pulse  out  1  one-cycle pulse on the cycle index changes

Behaviour:
- Reset: combo_reset has priority over all other inputs. It clears pwm_cnt, presc, index, duty_cur[], duty_active[] and step_pulse to 0. led = {NUM_CH{ACTIVE_LOW}} (all off) on the cycle after reset is sampled.
- PWM counter: pwm_cnt increments every clock and wraps all-ones -> 0. period_end = (pwm_cnt == all-ones).
- led output: led[c] <= (pwm_cnt < duty_active[c]) ^ ACTIVE_LOW, registered with 1-cycle latency.
  - duty 0 = never on.
  - duty D = on for D of every 2^PWM_BITS cycles.
  - Full-on is not reachable (max 2^PWM_BITS-1 of 2^PWM_BITS cycles).
- Glitch-free update: at period_end, duty_active[c] <= duty_cur[c]. New duty is visible starting with the next period.
- Target: target[c] = index[c] ? brightness : 0.
- Prescaler: at period_end with enable=1:
  - If presc == STEP_PERIODS-1: presc <= 0 and tick = 1.
  - Else: presc <= presc+1.
- STEP mode (mode=0):
  - duty_cur[c] <= target[c] every clock.
  - On tick, index <= index ± 1, modulo 2^NUM_CH (7->0 up, 0->7 down for NUM_CH=3).
- FADE mode (mode=1):
  - At each period_end with enable=1, every duty_cur[c] moves 1 LSB toward target[c], stopping exactly at target.
  - settled = all duty_cur == target.
  - A tick advances index only if settled on that same cycle; otherwise the tick is dropped and presc still resets.
- step_pulse = 1 for exactly the clock in which index is updated.
- Mode switch FADE->STEP takes effect next clock; duty_cur snaps to target. STEP->FADE starts ramping from the current duty_cur.
- A brightness change mid-fade retargets immediately; the ramp continues from the present value.
- enable=0: index, presc and duty_cur hold. duty_active still reloads at period_end, so output is stable at the last duty. A pending tick is not generated.
- Simultaneous tick with reset: reset wins.

Decomposition:
- Package axc3000_led_pkg:
  - MODE_STEP/MODE_FADE constants.
  - Parameter-range checks.
  - Function step_toward(cur, tgt) returning cur±1 saturating at tgt.
- Sub-module led_pwm_channel (one per channel, generate loop):
  - Holds duty_cur, duty_active, the comparator and the led register.
  - Reports a per-channel settled flag.
- Top-level parts: pwm_cnt, prescaler, index and step_pulse logic.

Test Plan:
All tests use NUM_CH=3, PWM_BITS=4, STEP_PERIODS=2, ACTIVE_LOW=0.
1. Reset then step: combo_reset high 3 cycles -> led=000, index=0, step_pulse=0. Release; enable=1, mode=0, up_down=1, brightness=15 -> index=1 after 32 clocks with a single-cycle step_pulse.
2. Duty accuracy: index=1, brightness=5 -> led[0] high exactly 5 of every 16 clocks, contiguous, starting 1 clock after pwm_cnt=0. led[2:1] stay 0.
3. Wrap and direction: at index=7 with up_down=1, next tick -> index=0. At index=0 with up_down=0 -> index=7.
4. Fade: mode=1, brightness=15, index 0->1 -> duty_active[0] rises by 1 per 16-clock period, 0..15. Ticks occurring before duty_cur[0]=15 leave index=1 with step_pulse=0. The first tick after settling advances index to 2.
5. Freeze: enable=0 for 100 periods mid-run -> index, presc and duty unchanged, led PWM pattern unchanged. Re-enable -> resumes from the held presc.
6. Reset mid-fade: pulse combo_reset for 1 cycle while duty_cur[0]=7 -> next cycle all duty, index and presc are 0, and led stays 000 for the following full period.
